// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory controller.
// Contents: word_t, access size encoding, controller state encoding and
// a helper returning the byte-lane mask for an access size.
// Build option: MEM_CTRL_MISALIGNED_EN adds the BEAT1 state for split accesses.
package mem_ctrl_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      BEAT0,
`ifdef MEM_CTRL_MISALIGNED_EN
      BEAT1,
`endif
      CAP,
      RESP
   } state_e;

   // Unshifted byte-lane mask for an access of the given size.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         SIZE_B:  return 4'h1;
         SIZE_H:  return 4'h3;
         default: return 4'hF;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_align.sv
// mem_align: combinational lane steering for the memory controller.
// Ports:
//   i_size, i_signed, i_offset : latched access size, sign flag, addr[1:0]
//   i_wdata                    : right-aligned store data
//   i_rdata                    : {beat1, beat0} raw RAM read data
//   o_wdata, o_be              : 64-bit lane-shifted store data and byte enables
//   o_rdata                    : right-aligned, masked, extended load data
module mem_align
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [1:0]  i_offset,
   input  word_t       i_wdata,
   input  logic [63:0] i_rdata,
   output logic [63:0] o_wdata,
   output logic [7:0]  o_be,
   output word_t       o_rdata
);

   logic [63:0] w_shifted;
   word_t       w_raw;

   always_comb begin
      o_be      = {4'b0000, size_mask(i_size)} << i_offset;
      o_wdata   = {32'b0, i_wdata} << {i_offset, 3'b000};
      w_shifted = i_rdata >> {i_offset, 3'b000};
      w_raw     = w_shifted[31:0];
      case (i_size)
         SIZE_B:  o_rdata = {{24{i_signed & w_raw[7]}}, w_raw[7:0]};
         SIZE_H:  o_rdata = {{16{i_signed & w_raw[15]}}, w_raw[15:0]};
         default: o_rdata = w_raw;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding load/store controller in front of a
// one-cycle-latency word RAM.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   req_*                           : core request (valid/ready handshake)
//   rsp_*                           : response (valid/ready handshake), fault flag
//   mem_addr/wdata/be/we, mem_rdata : RAM port, read data one cycle after address
// Build option: MEM_CTRL_MISALIGNED_EN enables two-beat accesses that cross a
// word boundary; without it such accesses fault.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  word_t       req_addr,
   input  word_t       req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output word_t       rsp_rdata,
   output logic        rsp_err,
   output logic [29:0] mem_addr,
   output word_t       mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_we,
   input  word_t       mem_rdata
);

   localparam logic [32:0] ByteLimit = 33'(MEM_WORDS) << 2;

   state_e      r_state, w_state_nxt;
   word_t       r_addr, r_wdata, r_rd0, r_rd1;
   logic [1:0]  r_size;
   logic        r_write, r_signed, r_err;
`ifdef MEM_CTRL_MISALIGNED_EN
   logic        r_split;
`endif

   logic        w_accept, w_split, w_fault, w_split_q, w_in_beat1;
   logic [3:0]  w_nbytes;
   logic [32:0] w_last;
   logic [63:0] w_wd64;
   logic [7:0]  w_be8;
   word_t       w_load;

   // Decode of the live request, used only on the accept cycle.
   always_comb begin
      w_nbytes = 4'd1 << req_size;
      w_split  = ({2'b00, req_addr[1:0]} + w_nbytes) > 4'd4;
      w_last   = {1'b0, req_addr} + {29'b0, w_nbytes} - 33'd1;
      w_fault  = (req_size == 2'd3) || (w_last >= ByteLimit);
`ifndef MEM_CTRL_MISALIGNED_EN
      w_fault  = w_fault || w_split;
`endif
   end

   assign w_accept = req_valid && (r_state == IDLE);

`ifdef MEM_CTRL_MISALIGNED_EN
   assign w_split_q  = r_split;
   assign w_in_beat1 = (r_state == BEAT1);
`else
   assign w_split_q  = 1'b0;
   assign w_in_beat1 = 1'b0;
`endif

   mem_align u_align (
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_offset (r_addr[1:0]),
      .i_wdata  (r_wdata),
      .i_rdata  ({r_rd1, r_rd0}),
      .o_wdata  (w_wd64),
      .o_be     (w_be8),
      .o_rdata  (w_load)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_size   <= '0;
         r_write  <= 1'b0;
         r_signed <= 1'b0;
         r_err    <= 1'b0;
         r_rd0    <= '0;
         r_rd1    <= '0;
`ifdef MEM_CTRL_MISALIGNED_EN
         r_split  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_size   <= req_size;
            r_write  <= req_write;
            r_signed <= req_signed;
            r_err    <= w_fault;
`ifdef MEM_CTRL_MISALIGNED_EN
            r_split  <= w_split;
`endif
         end
         // RAM data trails the address by one cycle: beat 0 data arrives in
         // the cycle after BEAT0, beat 1 data in CAP.
         if (w_in_beat1 || (r_state == CAP && !w_split_q)) r_rd0 <= mem_rdata;
         if (r_state == CAP && w_split_q) r_rd1 <= mem_rdata;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = (r_state == IDLE);
      rsp_valid   = (r_state == RESP);
      rsp_err     = (r_state == RESP) && r_err;
      rsp_rdata   = '0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_be      = '0;
      mem_we      = 1'b0;

      case (r_state)
         IDLE:  if (w_accept) w_state_nxt = w_fault ? RESP : BEAT0;
`ifdef MEM_CTRL_MISALIGNED_EN
         BEAT0: w_state_nxt = r_split ? BEAT1 : CAP;
         BEAT1: w_state_nxt = CAP;
`else
         BEAT0: w_state_nxt = CAP;
`endif
         CAP:   w_state_nxt = RESP;
         RESP:  if (rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      if (r_state == BEAT0 || w_in_beat1) begin
         mem_addr  = r_addr[31:2] + {29'b0, w_in_beat1};
         mem_be    = w_in_beat1 ? w_be8[7:4] : w_be8[3:0];
         mem_wdata = w_in_beat1 ? w_wd64[63:32] : w_wd64[31:0];
         mem_we    = r_write;
      end

      if (r_state == RESP && !r_err && !r_write) rsp_rdata = w_load;
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected responses
// and RAM beats into queues; two monitors pop and compare on the falling edge.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [31:0] rsp_rdata;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_we;

   mem_ctrl #(.MEM_WORDS(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } rsp_t;

   typedef struct {
      logic [29:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   rsp_t  rq[$];
   beat_t bq[$];
   rsp_t  cur;
   beat_t bt;
   bit    act = 1'b0;
   bit    run = 1'b0;
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;

   // RAM model: one-cycle read latency, byte-enabled writes.
   logic [31:0] ram [0:255];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_we && mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr[7:0]];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Response monitor: latency on first sight, data/err on every held cycle.
   always @(negedge clk) begin
      if (run && rsp_valid) begin
         if (!act) begin
            if (rq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got rdata %h err %b expected no response",
                        rsp_rdata, rsp_err);
            end else begin
               cur = rq.pop_front();
               act = 1'b1;
               check("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
            end
         end
         if (act) begin
            check("rsp_rdata", rsp_rdata, cur.rdata);
            check("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
         end
         if (rsp_ready) act = 1'b0;
      end
   end

   // RAM-side monitor: every cycle with an access must match an expected beat.
   always @(negedge clk) begin
      if (run && (mem_we || mem_be != 4'h0)) begin
         if (bq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got addr %h be %h we %b expected none",
                     mem_addr, mem_be, mem_we);
         end else begin
            bt = bq.pop_front();
            check("beat_addr", {2'b00, mem_addr}, {2'b00, bt.addr});
            check("beat_be", {28'b0, mem_be}, {28'b0, bt.be});
            check("beat_we", {31'b0, mem_we}, {31'b0, bt.we});
            if (bt.we) check("beat_wdata", mem_wdata, bt.wdata);
         end
      end
   end

   task automatic beat(input logic [29:0] a, input logic [3:0] be, input logic we,
                       input logic [31:0] wd);
      bq.push_back('{addr: a, be: be, we: we, wdata: wd});
   endtask

   // Drive one request, wait (bounded) for acceptance, then scramble req_*.
   // Returns just after the accept edge (DUT now in its first post-accept state).
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int elat,
                        input bit want_rsp);
      int c = 0;
      bit got = 1'b0;
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wd;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            c   = cyc;
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready 0 expected 1 within 20 cycles");
      end
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_size   = ~sz;
      req_signed = ~sg;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h5555_AAAA;
      if (got && want_rsp) rq.push_back('{rdata: erd, err: eerr, lat: elat, acc: c});
   endtask

   task automatic drain();
      int n = 0;
      while ((rq.size() != 0 || act) && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("rsp_drain", 32'(rq.size()) + {31'b0, act}, 32'd0);
      check("beat_drain", 32'(bq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 time units");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_be", {28'b0, mem_be}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      run = 1'b1;

      // Aligned word store and readback.
      beat(30'd4, 4'hF, 1'b1, 32'hDEAD_BEEF);
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b1);
      drain();
      beat(30'd4, 4'hF, 1'b0, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b1);
      drain();

      // Byte 0x80 at 0x13; word 4 becomes 0x80ADBEEF.
      beat(30'd4, 4'h8, 1'b1, 32'h8000_0000);
      issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, 32'h0, 1'b0, 3, 1'b1);
      drain();
      beat(30'd4, 4'h8, 1'b0, 32'h0);
      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b1);
      drain();
      beat(30'd4, 4'h8, 1'b0, 32'h0);
      issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 3, 1'b1);
      drain();

      // Halfword loads from word 4.
      beat(30'd4, 4'h3, 1'b0, 32'h0);
      issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, 1'b1);
      drain();
      beat(30'd4, 4'hC, 1'b0, 32'h0);
      issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000_80AD, 1'b0, 3, 1'b1);
      drain();

      // Split halfword store of 0xABCD at 0x0F and readback.
`ifdef MEM_CTRL_MISALIGNED_EN
      beat(30'd3, 4'h8, 1'b1, 32'hCD00_0000);
      beat(30'd4, 4'h1, 1'b1, 32'h0000_00AB);
      issue(1'b1, 2'd1, 1'b0, 32'h0F, 32'h0000_ABCD, 32'h0, 1'b0, 4, 1'b1);
      drain();
      beat(30'd3, 4'h8, 1'b0, 32'h0);
      beat(30'd4, 4'h1, 1'b0, 32'h0);
      issue(1'b0, 2'd1, 1'b0, 32'h0F, 32'h0, 32'h0000_ABCD, 1'b0, 4, 1'b1);
      drain();
`else
      issue(1'b1, 2'd1, 1'b0, 32'h0F, 32'h0000_ABCD, 32'h0, 1'b1, 1, 1'b1);
      drain();
      issue(1'b0, 2'd1, 1'b0, 32'h0F, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      drain();
`endif

      // Out-of-range, illegal size, last valid word, range-crossing half.
      issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      drain();
      issue(1'b1, 2'd3, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b1);
      drain();
      beat(30'd255, 4'hF, 1'b0, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0, 3, 1'b1);
      drain();
      issue(1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      drain();

      // Backpressure: hold rsp_ready low 5 cycles; monitor rechecks each cycle.
      rsp_ready = 1'b0;
      beat(30'd4, 4'hF, 1'b0, 32'h0);
`ifdef MEM_CTRL_MISALIGNED_EN
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80AD_BEAB, 1'b0, 3, 1'b1);
`else
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 3, 1'b1);
`endif
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      check("bp_valid_held", {31'b0, rsp_valid}, 32'd1);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      drain();

      // Reset in BEAT0 of a write: only beat 0 may appear, no response.
`ifdef MEM_CTRL_MISALIGNED_EN
      beat(30'd3, 4'h8, 1'b1, 32'h3400_0000);
      issue(1'b1, 2'd1, 1'b0, 32'h0F, 32'h0000_1234, 32'h0, 1'b0, 0, 1'b0);
`else
      beat(30'd8, 4'hF, 1'b1, 32'h1234_5678);
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 0, 1'b0);
`endif
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("post_rst_ready", {31'b0, req_ready}, 32'd1);
      check("post_rst_be", {28'b0, mem_be}, 32'd0);
      check("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
      repeat (4) @(negedge clk);
      drain();

      // Normal operation resumes; word 4 untouched by the abandoned write.
      beat(30'd4, 4'hF, 1'b0, 32'h0);
`ifdef MEM_CTRL_MISALIGNED_EN
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80AD_BEAB, 1'b0, 3, 1'b1);
`else
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 3, 1'b1);
`endif
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, number of 32-bit words in the attached RAM (1 KiB).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have core-side ports: req_valid in 1; req_ready out 1; req_write in 1; req_size in 2 (0 byte, 1 half, 2 word); req_signed in 1 (sign-extend loads); req_addr in 32 byte address; req_wdata in 32 store data, right-aligned.
REQ-004 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32 extended load data; rsp_err out 1 fault flag.
REQ-005 SHALL have RAM-side ports: mem_addr out 30 word index; mem_wdata out 32; mem_be out 4 byte-lane enables; mem_we out 1; mem_rdata in 32, valid exactly one cycle after mem_addr is driven.

Function
REQ-006 SHALL accept a request on a cycle where req_valid and req_ready are both high; req_ready SHALL be high only in IDLE.
REQ-007 SHALL implement states IDLE, BEAT0, BEAT1, CAP, RESP; IDLE->BEAT0 on accept; BEAT0->BEAT1 if split, else CAP; BEAT1->CAP; CAP->RESP; RESP->IDLE when rsp_ready.
REQ-008 SHALL treat an access as split when addr[1:0] + (1<<size) > 4; BEAT0 SHALL address word addr[31:2] and BEAT1 word addr[31:2]+1.
REQ-009 SHALL drive mem_be = size mask shifted left by addr[1:0] (low 4 bits in BEAT0, bits 7:4 in BEAT1); mem_wdata = req_wdata shifted by 8*addr[1:0] with the same lane split.
REQ-010 SHALL assert mem_we only in BEAT0/BEAT1 of a write, and hold mem_be at 0 outside BEAT0/BEAT1.
REQ-011 SHALL capture mem_rdata of beat 0 in the cycle after BEAT0 and of beat 1 in CAP, then right-shift, mask to size, and zero- or sign-extend per req_signed into rsp_rdata.
REQ-012 SHALL assert rsp_valid in RESP only: 3 cycles after accept for aligned, 4 for split; rsp_valid and rsp_rdata SHALL hold stable until rsp_ready.
REQ-013 SHALL return rsp_rdata = 0 for writes; a write SHALL still produce one response.
REQ-014 SHALL fault when any addressed byte is at or above MEM_WORDS*4, or req_size = 3: no RAM access, go IDLE->RESP directly, rsp_valid at accept+1, rsp_err = 1, rsp_rdata = 0.
REQ-015 SHALL latch all request fields at accept; later req_* changes SHALL not affect the transaction in flight.

Reset
REQ-016 SHALL on rst return to IDLE with req_ready = 1 and rsp_valid, rsp_err, mem_we, mem_be, rsp_rdata, mem_addr and mem_wdata all 0.
REQ-017 SHALL abandon any in-flight transaction on reset mid-operation with no response; a write already in BEAT0 SHALL not have its BEAT1 issued.

Configuration
REQ-018 SHALL, with MEM_CTRL_MISALIGNED_EN defined, perform split accesses per REQ-008.
REQ-019 SHALL, without MEM_CTRL_MISALIGNED_EN, fault every split access per REQ-014, and state BEAT1 SHALL be absent.

Structure
REQ-020 SHALL place size encoding enum (SIZE_B, SIZE_H, SIZE_W), the state enum, and word_t in the shared types package.
REQ-021 SHALL contain one combinational sub-module mem_align that performs lane shifting, masking and extension for both store and load paths.

Verification
REQ-022 SHALL test an aligned word store: write 0xDEADBEEF at addr 0x10, then read it back -> mem_be = 4'hF, rsp_rdata = 0xDEADBEEF at accept+3.
REQ-023 SHALL test a signed byte load of 0x80 at addr 0x13 -> rsp_rdata = 0xFFFFFF80; the unsigned load -> 0x00000080.
REQ-024 SHALL test a split half store of 0xABCD at addr 0x0F (macro defined) -> BEAT0 be = 4'h8, BEAT1 be = 4'h1 at word 4; readback = 0x0000ABCD at accept+4; without the macro -> rsp_err = 1 at accept+1 and no mem_we.
REQ-025 SHALL test a word read at addr 0x400 with MEM_WORDS = 256 -> rsp_err = 1, no mem access.
REQ-026 SHALL test backpressure and reset: hold rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable; assert rst in BEAT0 of a split write -> no BEAT1, IDLE next cycle.
